// File: rtl/data_ptr_pkg.sv
// Shared op-codes and state encoding for the data pointer controller.
package data_ptr_pkg;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_PTR_INC  = 3'd1;
    localparam logic [2:0] OP_PTR_DEC  = 3'd2;
    localparam logic [2:0] OP_CELL_ADD = 3'd3;
    localparam logic [2:0] OP_CELL_SET = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/data_ptr_ctrl.sv
// Data pointer / cell cache controller in front of a one-cycle, write-through data RAM.
// Optional macro DATA_PTR_BOUNDS_EN: pointer saturates at the ends and raises a sticky ptr_fault.
//
// state | meaning
// IDLE  | accepting ops; cell ops write through in the accept cycle
// FETCH | RAM registering data[pointer] after a move (also the post-reset state)
// LOAD  | ram_data_out valid; copied into the cell cache
module data_ptr_ctrl
    import data_ptr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic [2:0]            op_code,
    input  logic [DATA_WIDTH-1:0] op_arg,
    output logic                  op_ready,
    output logic [DATA_WIDTH-1:0] cell_value,
    output logic                  cell_zero,
    output logic [ADDR_WIDTH-1:0] pointer,
    output logic                  ptr_fault,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] cell_q, cell_d;
`ifdef DATA_PTR_BOUNDS_EN
    logic                  fault_q, fault_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            ptr_q   <= '0;
            cell_q  <= '0;
`ifdef DATA_PTR_BOUNDS_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cell_q  <= cell_d;
`ifdef DATA_PTR_BOUNDS_EN
            fault_q <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cell_d      = cell_q;
`ifdef DATA_PTR_BOUNDS_EN
        fault_d     = fault_q;
`endif
        op_ready    = (state_q == ST_IDLE);
        ram_write   = 1'b0;
        ram_data_in = cell_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_PTR_INC: begin
`ifdef DATA_PTR_BOUNDS_EN
                            if (ptr_q == '1) begin
                                fault_d = 1'b1;
                            end else begin
                                ptr_d   = ptr_q + PTR_ONE;
                                state_d = ST_FETCH;
                            end
`else
                            ptr_d   = ptr_q + PTR_ONE;
                            state_d = ST_FETCH;
`endif
                        end
                        OP_PTR_DEC: begin
`ifdef DATA_PTR_BOUNDS_EN
                            if (ptr_q == '0) begin
                                fault_d = 1'b1;
                            end else begin
                                ptr_d   = ptr_q - PTR_ONE;
                                state_d = ST_FETCH;
                            end
`else
                            ptr_d   = ptr_q - PTR_ONE;
                            state_d = ST_FETCH;
`endif
                        end
                        OP_CELL_ADD: begin
                            ram_write   = 1'b1;
                            ram_data_in = cell_q + op_arg;
                            cell_d      = cell_q + op_arg;
                        end
                        OP_CELL_SET: begin
                            ram_write   = 1'b1;
                            ram_data_in = op_arg;
                            cell_d      = op_arg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                cell_d  = ram_data_out;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cell_value  = cell_q;
    assign cell_zero   = (cell_q == '0);
    assign pointer     = ptr_q;
    assign ram_address = ptr_q;
`ifdef DATA_PTR_BOUNDS_EN
    assign ptr_fault   = fault_q;
`else
    assign ptr_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_data_ptr_ctrl.sv
// Self-checking bench for data_ptr_ctrl: behavioural RAM, directed table, reset corner, random ops vs model.
module tb_data_ptr_ctrl;
    import data_ptr_pkg::*;

    localparam int DW = 8;
    localparam int AW = 15;
    localparam int DEPTH = 1 << AW;
`ifdef DATA_PTR_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic [2:0]    op_code = 3'd0;
    logic [DW-1:0] op_arg = '0;
    logic          op_ready;
    logic [DW-1:0] cell_value;
    logic          cell_zero;
    logic [AW-1:0] pointer;
    logic          ptr_fault;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_write;
    logic [DW-1:0] ram_data_out = '0;

    data_ptr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_arg(op_arg),
        .op_ready(op_ready), .cell_value(cell_value), .cell_zero(cell_zero), .pointer(pointer),
        .ptr_fault(ptr_fault), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write(ram_write), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous write-through RAM, not cleared by reset
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write) begin
            mem[ram_address] = ram_data_in;
            ram_data_out <= ram_data_in;
        end else begin
            ram_data_out <= mem[ram_address];
        end
    end

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic [AW-1:0] m_ptr;
    logic [DW-1:0] m_cell;
    logic          m_fault;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_ptr"}, pointer, m_ptr);
        chk({tag, "_cell"}, cell_value, m_cell);
        chk({tag, "_zero"}, cell_zero, (m_cell == 0));
        chk({tag, "_fault"}, ptr_fault, m_fault);
        chk({tag, "_addr"}, ram_address, m_ptr);
    endtask

    // Counts cycles with op_ready low, holding a junk cell op that must be ignored
    task automatic count_stall(output int stall);
        stall = 0;
        op_valid = 1'b1;
        op_code = OP_CELL_SET;
        op_arg = 8'hEE;
        #1;
        while (!op_ready && stall < 8) begin
            chk("ram_write_while_busy", ram_write, 0);
            @(posedge clk); #1;
            stall++;
        end
        op_valid = 1'b0;
        if (stall >= 8) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [2:0] code, input logic [DW-1:0] arg);
        logic [DW-1:0] nv;
        bit is_cell, is_inc, is_dec, at_end;
        int stall, exp_stall;
        is_cell = (code == OP_CELL_ADD) || (code == OP_CELL_SET);
        is_inc  = (code == OP_PTR_INC);
        is_dec  = (code == OP_PTR_DEC);
        nv = (code == OP_CELL_ADD) ? DW'((int'(m_cell) + int'(arg)) % 256) : arg;
        op_valid = 1'b1; op_code = code; op_arg = arg;
        #1;
        chk("op_ready_idle", op_ready, 1);
        chk("ram_write", ram_write, is_cell);
        chk("ram_data_in", ram_data_in, is_cell ? nv : m_cell);
        exp_stall = 0;
        if (is_cell) begin
            m_mem[m_ptr] = nv;
            m_cell = nv;
        end else if (is_inc || is_dec) begin
            at_end = (is_inc && int'(m_ptr) == DEPTH - 1) || (is_dec && m_ptr == 0);
            if (BOUNDS && at_end) begin
                m_fault = 1'b1;
            end else begin
                m_ptr = AW'((int'(m_ptr) + (is_inc ? 1 : DEPTH - 1)) % DEPTH);
                m_cell = m_mem[m_ptr];
                exp_stall = 2;
            end
        end
        @(posedge clk); #1;
        count_stall(stall);
        chk("stall_cycles", stall, exp_stall);
        chk_state("op");
    endtask

    typedef struct {
        logic [2:0]    code;
        logic [DW-1:0] arg;
        logic [AW-1:0] exp_ptr;
        logic [DW-1:0] exp_cell;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int stall;
        tbl[0] = '{OP_CELL_SET, 8'h00, 15'h0000, 8'h00};
        tbl[1] = '{OP_CELL_ADD, 8'hFF, 15'h0000, 8'hFF};
        tbl[2] = '{OP_CELL_ADD, 8'h01, 15'h0000, 8'h00};
        tbl[3] = '{OP_CELL_SET, 8'h07, 15'h0000, 8'h07};
        tbl[4] = '{OP_PTR_INC,  8'h00, 15'h0001, 8'h55};
        tbl[5] = '{OP_CELL_SET, 8'h09, 15'h0001, 8'h09};
        tbl[6] = '{OP_PTR_DEC,  8'h00, 15'h0000, 8'h07};
        tbl[7] = '{3'd6,        8'h33, 15'h0000, 8'h07};
`ifdef DATA_PTR_BOUNDS_EN
        tbl[8] = '{OP_PTR_DEC,  8'h00, 15'h0000, 8'h07};
        tbl[9] = '{OP_PTR_INC,  8'h00, 15'h0001, 8'h09};
`else
        tbl[8] = '{OP_PTR_DEC,  8'h00, 15'h7FFF, 8'hC3};
        tbl[9] = '{OP_PTR_INC,  8'h00, 15'h0000, 8'h07};
`endif

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom);
        end
        mem[0] = 8'h2A; mem[1] = 8'h55; mem[DEPTH-1] = 8'hC3;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = mem[i];

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ptr", pointer, 0);
        chk("rst_cell", cell_value, 0);
        chk("rst_zero", cell_zero, 1);
        chk("rst_ready", op_ready, 0);
        chk("rst_write", ram_write, 0);
        chk("rst_fault", ptr_fault, 0);

        rst_n = 1'b1;
        m_ptr = '0; m_cell = m_mem[0]; m_fault = 1'b0;
        count_stall(stall);
        chk("rst_release_stall", stall, 2);
        chk("rst_reload_cell", cell_value, 8'h2A);
        chk_state("reload");

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].code, tbl[i].arg);
            chk($sformatf("tbl%0d_ptr", i), pointer, tbl[i].exp_ptr);
            chk($sformatf("tbl%0d_cell", i), cell_value, tbl[i].exp_cell);
        end
        chk("tbl_fault", ptr_fault, BOUNDS);

        // Reset asserted during LOAD of a pointer increment
        op_valid = 1'b1; op_code = OP_PTR_INC; op_arg = '0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ptr", pointer, 0);
        chk("midrst_ready", op_ready, 0);
        chk("midrst_write", ram_write, 0);
        chk("midrst_fault", ptr_fault, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = '0; m_cell = m_mem[0]; m_fault = 1'b0;
        count_stall(stall);
        chk("midrst_stall", stall, 2);
        chk("midrst_cell0", cell_value, 8'h07);
        chk_state("midrst");

        // Randomised ops and idle cycles against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                op_valid = 1'b0;
                op_code = 3'($urandom_range(0, 7));
                op_arg = DW'($urandom);
                #1;
                chk("idle_write", ram_write, 0);
                chk("idle_data_in", ram_data_in, m_cell);
                @(posedge clk); #1;
                chk_state("idle");
            end else begin
                do_op(3'($urandom_range(0, 7)), DW'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
